bsg_manycore_endpoint_out_credit: RTL and testbench
===================================================

# bsg_manycore_endpoint_out_credit

Outgoing-request credit gate that sits directly upstream of the manycore endpoint's local outgoing interface. It buffers request packets from the local client in a two-entry FIFO and holds a counter of credits for outstanding remote requests. A packet is released to the endpoint only when a credit is available. The endpoint's registered credit-return pulse restores a credit. A quiescence flag supports memory fences.

## Interface
Parameters:
- x_cord_width_p, "inv", mesh X coordinate width
- y_cord_width_p, "inv", mesh Y coordinate width
- data_width_p, 32, packet data width
- addr_width_p, 32, packet address width
- credits_p, 16, maximum outstanding requests (at least 1)
- packet_width_lp, `bsg_manycore_packet_width(addr_width_p,data_width_p,x_cord_width_p,y_cord_width_p)`, derived packet width
- credit_width_lp, `BSG_WIDTH(credits_p)`, which is $clog2(credits_p+1)

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- packet_i  in  packet_width_lp  request packet from the local client
- v_i  in  1  client valid
- ready_o  out  1  client ready (valid/ready handshake)
- out_packet_o  out  packet_width_lp  packet to the endpoint
- out_v_o  out  1  packet valid to the endpoint
- out_ready_i  in  1  endpoint ready
- credit_v_i  in  1  one-cycle credit return, driven by the endpoint's registered credit pulse
- credits_o  out  credit_width_lp  current available credits
- idle_o  out  1  buffer empty and all credits home
- error_o  out  1  sticky flag: credit returned while the counter was full

## Operation
- The buffer is a two-entry FIFO. It accepts a packet when v_i & ready_o.
- out_v_o = buf_v & (credits_r != 0).
- out_packet_o is the FIFO head.
- A send occurs when out_v_o & out_ready_i. The FIFO dequeues on a send.
- Credit counter update per cycle, with send = out_v_o & out_ready_i and ret = credit_v_i:
  - send only: credits_r - 1
  - ret only: credits_r + 1
  - send and ret together: credits_r unchanged
  - neither: credits_r unchanged
- The counter never underflows, because a send requires a nonzero count.
- If ret occurs with credits_r == credits_p and no send in that cycle:
  - the counter saturates at credits_p;
  - error_o sets and stays set until reset.
- idle_o = ~buf_v & (credits_r == credits_p).
- Packets are never reordered, dropped or modified.
- No state machine beyond the FIFO occupancy and the counter.

## Timing
- Reset values:
  - credits_r = credits_p
  - FIFO empty
  - out_v_o = 0
  - ready_o = 1 (after reset deasserts)
  - idle_o = 1
  - error_o = 0
- Reset takes effect immediately, regardless of the clock edge.
- Asserting reset mid-operation flushes buffered packets and restores all credits. Outstanding returns arriving after reset cause a saturate plus error, which is the intended flag.
- ready_o depends only on registered FIFO state; there is no combinational path from out_ready_i.
- Latency: a packet accepted at edge t is presented at out_v_o in cycle t+1, if a credit is available.
- Full throughput: one packet per cycle while credits last and out_ready_i = 1.
- Credit usability:
  - A credit returned in cycle t is usable in cycle t+1.
  - With credits_r == 0 in cycle t and credit_v_i = 1 in cycle t, out_v_o is 0 in t and 1 in t+1.
- out_v_o may deassert without a send, when the last credit is consumed. Once asserted with a credit present, out_v_o stays high until the send.
- The FIFO is full with 2 entries: ready_o = 0. An enqueue and a dequeue in the same cycle while full is not allowed, because ready_o is registered.

## Structure
- The packet width macro comes from the shared manycore packet package. No new typedefs are required.
- Sub-module: bsg_two_fifo (width_p = packet_width_lp) provides the buffer.
- The top level holds only the credit counter, the error flag and the gating logic. Expected size is about 120-150 lines.

## Test plan
- **Reset idle:** deassert reset with no traffic -> credits_o = 16, idle_o = 1, error_o = 0, out_v_o = 0, ready_o = 1.
- **Credit exhaustion:** credits_p = 2, stream 4 packets with out_ready_i = 1 and no returns -> 2 sends in consecutive cycles, credits_o = 0, FIFO holds 2 packets, ready_o = 0, out_v_o = 0.
- **Credit return resume:** from exhaustion, pulse credit_v_i for one cycle at cycle t -> exactly one send in cycle t+1, credits_o = 0 after the send, next packet held.
- **Simultaneous send and return:** credits_o = 1, send and credit_v_i in the same cycle -> credits_o stays 1 and the next packet sends in the following cycle.
- **Backpressure ordering:** toggle out_ready_i randomly with packet payloads 0x1..0x20 -> output order matches input order, with no loss and no duplication.
- **Overflow and reset:**
  - credits_o = 16, pulse credit_v_i -> credits_o stays 16, error_o = 1 and stays 1.
  - Assert reset asynchronously mid-cycle -> error_o = 0 immediately, FIFO flushed.

Source files
------------

// File: rtl/bsg_manycore_endpoint_out_credit_pkg.sv
// Shared sizing helpers for the manycore outgoing-request credit gate.
// Packet layout: op, byte mask, address, data, source and destination coordinates.
package bsg_manycore_endpoint_out_credit_pkg;

    localparam int unsigned OP_WIDTH   = 2;
    localparam int unsigned MASK_WIDTH = 4;

    // Width of a manycore request packet for the given field widths.
    function automatic int unsigned bsg_manycore_packet_width(
        input int unsigned addr_width,
        input int unsigned data_width,
        input int unsigned x_cord_width,
        input int unsigned y_cord_width
    );
        return OP_WIDTH + MASK_WIDTH + addr_width + data_width
             + 2 * (x_cord_width + y_cord_width);
    endfunction

    // Bits needed to hold a count from 0 to max_val inclusive.
    function automatic int unsigned bsg_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bsg_manycore_endpoint_out_credit_two_fifo.sv
// Two-entry FIFO with valid/ready input and valid/yumi output.
// ready_o comes only from the registered occupancy count.
module bsg_two_fifo #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] r_mem [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;
    logic               w_enq;
    logic               w_deq;

    assign ready_o = (r_count != 2'd2);
    assign v_o     = (r_count != 2'd0);
    assign data_o  = r_mem[r_rd_ptr];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; it is only read while v_o is high.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_manycore_endpoint_out_credit.sv
// Outgoing-request credit gate: buffers client packets and releases them to the
// endpoint only while a credit for an outstanding remote request is available.
module bsg_manycore_endpoint_out_credit
    import bsg_manycore_endpoint_out_credit_pkg::*;
#(
    parameter int unsigned x_cord_width_p  = 4,
    parameter int unsigned y_cord_width_p  = 4,
    parameter int unsigned data_width_p    = 32,
    parameter int unsigned addr_width_p    = 32,
    parameter int unsigned credits_p       = 16,
    parameter int unsigned packet_width_lp =
        bsg_manycore_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    parameter int unsigned credit_width_lp = bsg_width(credits_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [packet_width_lp-1:0] packet_i,
    input  logic                       v_i,
    output logic                       ready_o,
    output logic [packet_width_lp-1:0] out_packet_o,
    output logic                       out_v_o,
    input  logic                       out_ready_i,
    input  logic                       credit_v_i,
    output logic [credit_width_lp-1:0] credits_o,
    output logic                       idle_o,
    output logic                       error_o
);

    localparam logic [credit_width_lp-1:0] CREDITS_MAX = credit_width_lp'(credits_p);
    localparam logic [credit_width_lp-1:0] CREDIT_ONE  = credit_width_lp'(1);

    logic [credit_width_lp-1:0] r_credits;
    logic [credit_width_lp-1:0] w_credits_n;
    logic                       r_error;
    logic                       w_error_n;
    logic                       w_buf_v;
    logic                       w_send;
    logic                       w_ret;
    logic                       w_at_max;

    bsg_two_fifo #(
        .width_p (packet_width_lp)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (packet_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .data_o  (out_packet_o),
        .v_o     (w_buf_v),
        .yumi_i  (w_send)
    );

    assign out_v_o  = w_buf_v & (r_credits != '0);
    assign w_send   = out_v_o & out_ready_i;
    assign w_ret    = credit_v_i;
    assign w_at_max = (r_credits == CREDITS_MAX);

    // A return with the counter already full saturates and raises the sticky error.
    always_comb begin
        w_credits_n = r_credits;
        w_error_n   = r_error;
        case ({w_send, w_ret})
            2'b10: w_credits_n = r_credits - CREDIT_ONE;
            2'b01: begin
                if (w_at_max) begin
                    w_error_n = 1'b1;
                end else begin
                    w_credits_n = r_credits + CREDIT_ONE;
                end
            end
            default: w_credits_n = r_credits;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_credits <= CREDITS_MAX;
            r_error   <= 1'b0;
        end else begin
            r_credits <= w_credits_n;
            r_error   <= w_error_n;
        end
    end

    assign credits_o = r_credits;
    assign idle_o    = ~w_buf_v & w_at_max;
    assign error_o   = r_error;

endmodule

// File: tb/tb_bsg_manycore_endpoint_out_credit.sv
// Directed and randomized checks of the credit gate against a queue-based model.
module tb_bsg_manycore_endpoint_out_credit;
    import bsg_manycore_endpoint_out_credit_pkg::*;

    localparam int unsigned PW   = bsg_manycore_packet_width(32, 32, 4, 4);
    localparam int unsigned CW16 = bsg_width(16);
    localparam int unsigned CW2  = bsg_width(2);

    logic clk;
    logic rst;
    logic sel;
    logic [PW-1:0] pkt;
    logic v, out_ready, credit;

    logic [PW-1:0]   pkt16, pkt2;
    logic            rdy16, rdy2, ov16, ov2, idle16, idle2, err16, err2;
    logic [CW16-1:0] cr16;
    logic [CW2-1:0]  cr2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] mq[$];
    logic [PW-1:0] rx[$];
    int  m_cr;
    int  cap;
    bit  m_err;
    bit  last_acc;
    int  n_sends;

    bsg_manycore_endpoint_out_credit #(
        .x_cord_width_p (4), .y_cord_width_p (4),
        .data_width_p (32), .addr_width_p (32), .credits_p (16)
    ) u_dut16 (
        .clk_i (clk), .reset_i (rst),
        .packet_i (pkt), .v_i (v & ~sel), .ready_o (rdy16),
        .out_packet_o (pkt16), .out_v_o (ov16), .out_ready_i (out_ready & ~sel),
        .credit_v_i (credit & ~sel), .credits_o (cr16), .idle_o (idle16), .error_o (err16)
    );

    bsg_manycore_endpoint_out_credit #(
        .x_cord_width_p (4), .y_cord_width_p (4),
        .data_width_p (32), .addr_width_p (32), .credits_p (2)
    ) u_dut2 (
        .clk_i (clk), .reset_i (rst),
        .packet_i (pkt), .v_i (v & sel), .ready_o (rdy2),
        .out_packet_o (pkt2), .out_v_o (ov2), .out_ready_i (out_ready & sel),
        .credit_v_i (credit & sel), .credits_o (cr2), .idle_o (idle2), .error_o (err2)
    );

    wire [PW-1:0] obs_pkt  = sel ? pkt2 : pkt16;
    wire          obs_v    = sel ? ov2 : ov16;
    wire          obs_rdy  = sel ? rdy2 : rdy16;
    wire          obs_idle = sel ? idle2 : idle16;
    wire          obs_err  = sel ? err2 : err16;
    wire [7:0]    obs_cr   = sel ? 8'(cr2) : 8'(cr16);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cr  = cap;
        m_err = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit exp_v, exp_rdy, send, acc;
        @(negedge clk);
        exp_v   = (mq.size() > 0) && (m_cr > 0);
        exp_rdy = (mq.size() < 2);
        chk("out_v",   128'(obs_v),    128'(exp_v));
        chk("ready",   128'(obs_rdy),  128'(exp_rdy));
        chk("credits", 128'(obs_cr),   128'(m_cr));
        chk("idle",    128'(obs_idle), 128'((mq.size() == 0) && (m_cr == cap)));
        chk("error",   128'(obs_err),  128'(m_err));
        if (exp_v) chk("out_packet", 128'(obs_pkt), 128'(mq[0]));
        @(posedge clk);
        send = exp_v && out_ready;
        acc  = v && exp_rdy;
        if (send) begin
            rx.push_back(mq.pop_front());
            n_sends++;
        end
        if (acc) mq.push_back(pkt);
        last_acc = acc;
        if (send && !credit) m_cr--;
        else if (credit && !send) begin
            if (m_cr == cap) m_err = 1'b1;
            else m_cr++;
        end
        #1;
    endtask

    task automatic do_reset(input logic s);
        v = 0; out_ready = 0; credit = 0; pkt = '0;
        rst = 1'b1;
        sel = s;
        cap = s ? 2 : 16;
        model_reset();
        rx.delete();
        n_sends = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int next, guard;
        rst = 1'b1; sel = 1'b0; v = 0; out_ready = 0; credit = 0; pkt = '0;
        cap = 16; last_acc = 0; n_sends = 0;
        model_reset();

        // Reset idle on the 16-credit instance.
        do_reset(1'b0);
        cycle();
        cycle();

        // Credit exhaustion with 2 credits.
        do_reset(1'b1);
        for (int i = 1; i <= 4; i++) begin
            v = 1; pkt = PW'(i); out_ready = 1;
            cycle();
        end
        v = 0;
        cycle();
        chk("exhaust_sends", 128'(n_sends), 128'(2));
        chk("exhaust_ready", 128'(obs_rdy), 128'(0));

        // Single return releases exactly one packet one cycle later.
        credit = 1; cycle();
        credit = 0; cycle();
        cycle();
        chk("resume_sends", 128'(n_sends), 128'(3));

        // Simultaneous send and return keeps the count.
        out_ready = 0; credit = 1; cycle();
        credit = 0; v = 1; pkt = PW'(5); cycle();
        v = 0; out_ready = 1; credit = 1; cycle();
        chk("simul_credits", 128'(obs_cr), 128'(1));
        credit = 0; cycle();
        cycle();
        chk("simul_sends", 128'(n_sends), 128'(5));

        // Backpressure ordering with random ready and random credit returns.
        do_reset(1'b1);
        next = 1;
        guard = 0;
        while (rx.size() < 32 && guard < 3000) begin
            v         = (next <= 32) ? 1'($urandom_range(0, 1)) : 1'b0;
            pkt       = PW'(next);
            out_ready = 1'($urandom_range(0, 1));
            credit    = (m_cr < cap) && ($urandom_range(0, 2) != 0);
            cycle();
            if (last_acc) next++;
            guard++;
        end
        v = 0; out_ready = 0; credit = 0;
        chk("order_count", 128'(rx.size()), 128'(32));
        for (int i = 0; i < rx.size(); i++) begin
            chk("order_pkt", 128'(rx[i]), 128'(i + 1));
        end

        // Overflow on a full counter, then asynchronous mid-cycle reset.
        do_reset(1'b0);
        cycle();
        v = 1; pkt = PW'('hA1); cycle();
        pkt = PW'('hA2); cycle();
        v = 0; credit = 1; cycle();
        credit = 0; cycle();
        cycle();
        chk("overflow_error", 128'(obs_err), 128'(1));
        chk("overflow_credits", 128'(obs_cr), 128'(16));
        #2;
        rst = 1'b1;
        #1;
        chk("async_error",   128'(obs_err),  128'(0));
        chk("async_out_v",   128'(obs_v),    128'(0));
        chk("async_idle",    128'(obs_idle), 128'(1));
        chk("async_credits", 128'(obs_cr),   128'(16));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1;
        cycle();
        cycle();
        chk("flush_sends", 128'(rx.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
